seven_seg_readback: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seg_pattern_to_hex.sv | 34 +++
 rtl/seven_seg_readback.sv | 94 +++++++++
 tb/tb_seven_seg_readback.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph table and types shared by the seven-segment display and readback ends
package seven_seg_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seg_pattern_to_hex.sv
// seg_pattern_to_hex: maps an active-low segment pattern back to its hex digit
module seg_pattern_to_hex
  import seven_seg_pkg::*;
(
  input  seg_t    seg,
  output nibble_t hex,
  output logic    match,
  output logic    blank
);
  always_comb begin
    match = 1'b1;
    hex = '0;
    case (seg)
      SEG_0: hex = 4'h0;
      SEG_1: hex = 4'h1;
      SEG_2: hex = 4'h2;
      SEG_3: hex = 4'h3;
      SEG_4: hex = 4'h4;
      SEG_5: hex = 4'h5;
      SEG_6: hex = 4'h6;
      SEG_7: hex = 4'h7;
      SEG_8: hex = 4'h8;
      SEG_9: hex = 4'h9;
      SEG_A: hex = 4'hA;
      SEG_B: hex = 4'hB;
      SEG_C: hex = 4'hC;
      SEG_D: hex = 4'hD;
      SEG_E: hex = 4'hE;
      SEG_F: hex = 4'hF;
      default: match = 1'b0;
    endcase
  end
  assign blank = seg == SEG_BLANK;
endmodule

// File: rtl/seven_seg_readback.sv
// seven_seg_readback: recovers the hex word shown on a multiplexed active-low seven-segment bus
module seven_seg_readback
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic [2:0]              err_digit
);
  localparam int SMP_W = NUM_DIGITS + 7;
  logic [SMP_W-1:0] smp_d, smp_q, prev_d, prev_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic captured_d, captured_q;
  logic [NUM_DIGITS-1:0] seen_d, seen_q, valid_d, valid_q, sel_n;
  logic [4*NUM_DIGITS-1:0] value_d, value_q;
  logic fd_d, fd_q, err_d, err_q;
  logic [2:0] err_digit_d, err_digit_q, idx;
  logic legal, same, capture, match, blank, bad;
  nibble_t hex;
  seg_t pat;
  seg_pattern_to_hex u_dec (.seg(pat), .hex(hex), .match(match), .blank(blank));
  always_comb begin
    smp_d = {an, seg};
    prev_d = smp_q;
    sel_n = smp_q[SMP_W-1:7];
    pat = smp_q[6:0];
    legal = $onehot(~sel_n);
    same = smp_q == prev_q;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!sel_n[i]) idx = 3'(i);
    capture = legal && same && cnt_q == CNT_W'(STABLE_CYCLES - 1) && !captured_q;
    bad = capture && !match && !blank;
    cnt_d = !(legal && same) ? '0 : cnt_q == CNT_W'(STABLE_CYCLES) ? cnt_q : cnt_q + 1'b1;
    captured_d = same && (captured_q || capture);
    fd_d = &seen_q;
    seen_d = fd_d ? '0 : seen_q | (capture ? NUM_DIGITS'(1) << idx : '0);
    value_d = value_q;
    valid_d = valid_q;
    if (capture) valid_d[idx] = match;
    if (capture && match) value_d[{idx, 2'b00} +: 4] = hex;
    err_d = err_q || bad;
    err_digit_d = bad ? idx : err_digit_q;
    if (clear) begin
      cnt_d = '0;
      captured_d = 1'b0;
      seen_d = '0;
      fd_d = 1'b0;
      value_d = '0;
      valid_d = '0;
      err_d = 1'b0;
      err_digit_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    smp_q <= smp_d;
    prev_q <= prev_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      captured_q <= 1'b0;
      seen_q <= '0;
      fd_q <= 1'b0;
      value_q <= '0;
      valid_q <= '0;
      err_q <= 1'b0;
      err_digit_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      captured_q <= captured_d;
      seen_q <= seen_d;
      fd_q <= fd_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q <= err_d;
      err_digit_q <= err_digit_d;
    end
  end
  assign value = value_q;
  assign digit_valid = valid_q;
  assign frame_done = fd_q;
  assign pattern_err = err_q;
  assign err_digit = err_digit_q;
endmodule

// File: tb/tb_seven_seg_readback.sv
// tb_seven_seg_readback: directed scenarios plus random scans against a behavioural readback model
module tb_seven_seg_readback;
  localparam int ND = 8;
  localparam int S = 4;
  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 1'b0;
  logic reset, clear;
  logic [ND-1:0] an;
  logic [6:0] seg;
  logic [4*ND-1:0] value;
  logic [ND-1:0] digit_valid;
  logic frame_done, pattern_err;
  logic [2:0] err_digit;
  int vectors = 0;
  int miscompares = 0;
  logic [ND+6:0] m_s1, m_s2;
  int m_streak;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0] m_valid, m_seen;
  logic m_fd, m_err;
  logic [2:0] m_errd;
  seven_seg_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .clear(clear), .value(value),
    .digit_valid(digit_valid), .frame_done(frame_done), .pattern_err(pattern_err), .err_digit(err_digit)
  );
  always #5 clk = ~clk;
  // A dwell is taken when the same legal selection has been seen on S+1 consecutive
  // pin samples; the frame pulse comes one cycle after the slot set fills up.
  task automatic model_update();
    int zeros, k;
    logic hit;
    logic [3:0] h;
    if (reset || clear) begin
      m_streak = 0; m_value = '0; m_valid = '0; m_seen = '0;
      m_fd = 1'b0; m_err = 1'b0; m_errd = '0;
    end else begin
      m_fd = (m_seen == {ND{1'b1}});
      if (m_fd) m_seen = '0;
      zeros = 0; k = 0;
      for (int i = 0; i < ND; i++) if (!m_s1[7+i]) begin zeros++; k = i; end
      m_streak = (zeros == 1 && m_s1 == m_s2) ? m_streak + 1 : 0;
      if (m_streak == S) begin
        hit = 1'b0; h = '0;
        for (int j = 0; j < 16; j++) if (m_s1[6:0] == GLY[j]) begin hit = 1'b1; h = j[3:0]; end
        m_valid[k] = hit;
        if (hit) m_value[k*4 +: 4] = h;
        else if (m_s1[6:0] != 7'h7F) begin m_err = 1'b1; m_errd = k[2:0]; end
        m_seen[k] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = {an, seg};
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic idle_clear();
    an = '1; step(); step();
    clear = 1'b1; step(); clear = 1'b0;
  endtask
  task automatic show(input int d, input logic [6:0] p, input int n);
    an = ~(ND'(1) << d); seg = p;
    for (int c = 0; c < n; c++) step();
  endtask
  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; an = 8'hFE; seg = 7'h40;
    for (int c = 0; c < 3; c++) step();
    vectors++;
    if ({value, digit_valid, frame_done, pattern_err, err_digit} !== '0) begin
      $display("FAIL reset_outputs: got %h/%h/%b/%b/%0d want all zero", value, digit_valid, frame_done, pattern_err, err_digit);
      miscompares++;
    end
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      vectors++;
      if (digit_valid !== (c >= S ? 8'h01 : 8'h00) || value !== '0) begin
        $display("FAIL reset_release_c%0d: got valid=%h value=%h want valid=%h value=0", c, digit_valid, value, c >= S ? 8'h01 : 8'h00);
        miscompares++;
      end
    end
  endtask
  task automatic test_full_frame();
    int cap_i, fd_i, fd_cnt, early;
    cap_i = -1; fd_i = -1; fd_cnt = 0; early = 0;
    idle_clear();
    for (int d = 0; d < ND; d++) begin
      an = ~(ND'(1) << d); seg = GLY[d+1];
      for (int c = 0; c < 10; c++) begin
        step();
        if (frame_done && d < 7) early++;
        if (d == 7 && digit_valid[7] && cap_i < 0) cap_i = c;
        if (d == 7 && frame_done) begin fd_cnt++; fd_i = c; end
      end
    end
    vectors++;
    if (value !== 32'h87654321 || digit_valid !== 8'hFF) begin
      $display("FAIL frame_word: got %h/%h want 87654321/ff", value, digit_valid);
      miscompares++;
    end
    vectors++;
    if (fd_cnt != 1 || early != 0 || cap_i < 0 || fd_i != cap_i + 1) begin
      $display("FAIL frame_done_pulse: got count=%0d early=%0d at=%0d cap=%0d want 1 pulse right after capture", fd_cnt, early, fd_i, cap_i);
      miscompares++;
    end
  endtask
  task automatic test_short_dwell();
    int rises, saw3;
    logic pv;
    rises = 0; saw3 = 0; pv = 1'b0;
    idle_clear();
    an = 8'hFB;
    seg = 7'h30;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) seg = 7'h00;
      step();
      if (digit_valid[2] && value[11:8] == 4'h3) saw3++;
      if (digit_valid[2] && !pv) rises++;
      pv = digit_valid[2];
    end
    vectors++;
    if (value[11:8] !== 4'h8 || saw3 != 0 || rises != 1) begin
      $display("FAIL short_dwell: got nibble=%h seen3=%0d captures=%0d want 8/0/1", value[11:8], saw3, rises);
      miscompares++;
    end
  endtask
  task automatic test_bad_pattern();
    idle_clear();
    show(5, 7'h12, 10);
    show(5, 7'h7E, 10);
    vectors++;
    if (pattern_err !== 1'b1 || err_digit !== 3'd5 || digit_valid[5] !== 1'b0 || value[23:20] !== 4'h5) begin
      $display("FAIL bad_pattern: got err=%b idx=%0d valid5=%b nib=%h want 1/5/0/5", pattern_err, err_digit, digit_valid[5], value[23:20]);
      miscompares++;
    end
    idle_clear();
    vectors++;
    if (pattern_err !== 1'b0 || value !== '0 || digit_valid !== '0) begin
      $display("FAIL clear_after_err: got err=%b value=%h valid=%h want 0/0/0", pattern_err, value, digit_valid);
      miscompares++;
    end
  endtask
  task automatic test_blank_illegal();
    logic [4*ND+ND+4:0] snap;
    int changed;
    changed = 0;
    show(3, 7'h08, 10);
    vectors++;
    if (digit_valid[3] !== 1'b1 || value[15:12] !== 4'hA) begin
      $display("FAIL glyph_A: got valid3=%b nib=%h want 1/a", digit_valid[3], value[15:12]);
      miscompares++;
    end
    show(3, 7'h7F, 10);
    vectors++;
    if (digit_valid[3] !== 1'b0 || value[15:12] !== 4'hA || pattern_err !== 1'b0) begin
      $display("FAIL blank: got valid3=%b nib=%h err=%b want 0/a/0", digit_valid[3], value[15:12], pattern_err);
      miscompares++;
    end
    snap = {value, digit_valid, frame_done, pattern_err, err_digit};
    an = 8'hFC; seg = 7'h40;
    for (int c = 0; c < 20; c++) begin
      step();
      if ({value, digit_valid, frame_done, pattern_err, err_digit} != snap) changed++;
    end
    vectors++;
    if (changed != 0) begin
      $display("FAIL multi_anode: got %0d changed cycles want 0", changed);
      miscompares++;
    end
  endtask
  task automatic test_clear_collision();
    int fd1, fd2, fd3;
    fd1 = 0; fd2 = 0; fd3 = 0;
    idle_clear();
    for (int d = 1; d < ND; d++) show(d, GLY[d], 10);
    an = 8'hFE; seg = 7'h10;
    for (int c = 0; c < 5; c++) step();
    vectors++;
    if (digit_valid !== 8'hFE) begin
      $display("FAIL pre_collision: got valid=%h want fe", digit_valid);
      miscompares++;
    end
    clear = 1'b1; step(); clear = 1'b0; an = '1;
    vectors++;
    if (value !== '0 || digit_valid !== '0) begin
      $display("FAIL clear_vs_capture: got value=%h valid=%h want 0/0", value, digit_valid);
      miscompares++;
    end
    for (int c = 0; c < 4; c++) begin step(); if (frame_done) fd1++; end
    for (int d = 1; d < ND; d++) begin
      an = ~(ND'(1) << d); seg = GLY[d];
      for (int c = 0; c < 10; c++) begin step(); if (frame_done) fd2++; end
    end
    an = 8'hFE; seg = 7'h10;
    for (int c = 0; c < 10; c++) begin step(); if (frame_done) fd3++; end
    vectors++;
    if (fd1 != 0 || fd2 != 0 || fd3 != 1) begin
      $display("FAIL rescan_frame: got pulses %0d/%0d/%0d want 0/0/1", fd1, fd2, fd3);
      miscompares++;
    end
  endtask
  task automatic test_random();
    int n, r, k1, k2, dwell;
    n = 0;
    while (n < 600) begin
      r = $urandom_range(0, 9);
      k1 = $urandom_range(0, ND - 1);
      k2 = (k1 + $urandom_range(1, ND - 1)) % ND;
      an = r < 7 ? ~(ND'(1) << k1) : r == 7 ? '1 : ~((ND'(1) << k1) | (ND'(1) << k2));
      r = $urandom_range(0, 19);
      seg = r < 16 ? GLY[r] : r == 16 ? 7'h7F : 7'($urandom);
      dwell = $urandom_range(1, 10);
      for (int c = 0; c < dwell; c++) begin
        clear = $urandom_range(0, 59) == 0;
        reset = $urandom_range(0, 199) == 0;
        step();
        n++;
        vectors++;
        if ({value, digit_valid, frame_done, pattern_err, err_digit} !== {m_value, m_valid, m_fd, m_err, m_errd}) begin
          $display("FAIL random_c%0d: got %h/%h/%b/%b/%0d want %h/%h/%b/%b/%0d", n, value, digit_valid, frame_done,
                   pattern_err, err_digit, m_value, m_valid, m_fd, m_err, m_errd);
          miscompares++;
        end
      end
    end
    clear = 1'b0; reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_full_frame();
    test_short_dwell();
    test_bad_pattern();
    test_blank_illegal();
    test_clear_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
